// File: rtl/spi_baud_gen.sv
// -----------------------------------------------------------------------------
// spi_baud_gen
//
// Baud-rate generator and transfer sequencer for an SPI master. While a
// transfer runs, the block produces the baud clock that feeds the SCK control
// stage. The clock has NBITS periods, and each period has a low half and a
// high half of H system clocks:
//
//   H = (SPPR + 1) * 2^SPR          (1 .. 1024 clk cycles)
//
// The rate inputs are captured when the transfer starts. Later changes to
// SPPR/SPR do not affect the transfer that is already running.
//
// Ports
//   clk         system clock; all state changes on the rising edge
//   rst_n       asynchronous active-low reset
//   start       request one transfer (accepted only while idle)
//   abort       terminate a running transfer; blocks start while idle
//   SPPR[2:0]   baud pre-selection
//   SPR[2:0]    baud selection (power of two)
//   M_BaudRate  baud clock: low first half-period, high second half-period
//   idle        high when no transfer is in progress
//   bit_idx     index of the current SCK cycle, 0..NBITS-1
//   done        one-cycle pulse after a transfer completes normally
//
// Every output comes straight from a flop. The output flops are loaded from
// the *next* state, so they line up with the state registers without adding
// a cycle of latency.
// -----------------------------------------------------------------------------
module spi_baud_gen #(
  parameter int NBITS = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [2:0] SPPR,
  input  logic [2:0] SPR,
  output logic       M_BaudRate,
  output logic       idle,
  output logic [3:0] bit_idx,
  output logic       done
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // The last half-period of the transfer. The half-period counter h runs
  // from 0 up to this value.
  localparam logic [4:0] H_LAST = 5'(2 * NBITS - 1);

  // Reload value for the half-period down-counter: H-1.
  // The largest H is 8 << 7 = 1024, so the arithmetic is 11 bits wide.
  function automatic logic [10:0] half_len_m1(input logic [2:0] pre,
                                              input logic [2:0] sel);
    logic [10:0] len;
    len = ({8'd0, pre} + 11'd1) << sel;
    return len - 11'd1;
  endfunction

  logic [0:0]  state_q,   state_d;
  logic [10:0] div_cnt_q, div_cnt_d;
  logic [4:0]  h_q,       h_d;
  logic [2:0]  sppr_q,    sppr_d;
  logic [2:0]  spr_q,     spr_d;
  logic        baud_q,    baud_d;
  logic        idle_q,    idle_d;
  logic [3:0]  bit_idx_q, bit_idx_d;
  logic        done_q,    done_d;
  logic        run_d;

  // Next-state logic
  always_comb begin
    state_d   = state_q;
    div_cnt_d = div_cnt_q;
    h_d       = h_q;
    sppr_d    = sppr_q;
    spr_d     = spr_q;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // abort has priority over start, so both together keep the block idle
        if (start && !abort) begin
          state_d   = ST_RUN;
          sppr_d    = SPPR;
          spr_d     = SPR;
          div_cnt_d = half_len_m1(SPPR, SPR);
          h_d       = 5'd0;
        end
      end

      ST_RUN: begin
        if (abort) begin
          state_d   = ST_IDLE;
          div_cnt_d = 11'd0;
          h_d       = 5'd0;
        end else if (div_cnt_q == 11'd0) begin
          if (h_q == H_LAST) begin
            state_d = ST_IDLE;
            h_d     = 5'd0;
            done_d  = 1'b1;
          end else begin
            // Use the latched rate, not the live inputs
            h_d       = h_q + 5'd1;
            div_cnt_d = half_len_m1(sppr_q, spr_q);
          end
        end else begin
          div_cnt_d = div_cnt_q - 11'd1;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        div_cnt_d = 11'd0;
        h_d       = 5'd0;
      end
    endcase
  end

  // Output flops are loaded from the next state, so outputs follow the state
  // on the same edge without any combinational path to the ports.
  always_comb begin
    run_d     = (state_d == ST_RUN);
    baud_d    = run_d & h_d[0];
    idle_d    = ~run_d;
    bit_idx_d = run_d ? h_d[4:1] : 4'd0;
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      div_cnt_q <= 11'd0;
      h_q       <= 5'd0;
      sppr_q    <= 3'd0;
      spr_q     <= 3'd0;
      baud_q    <= 1'b0;
      idle_q    <= 1'b1;
      bit_idx_q <= 4'd0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cnt_q <= div_cnt_d;
      h_q       <= h_d;
      sppr_q    <= sppr_d;
      spr_q     <= spr_d;
      baud_q    <= baud_d;
      idle_q    <= idle_d;
      bit_idx_q <= bit_idx_d;
      done_q    <= done_d;
    end
  end

  assign M_BaudRate = baud_q;
  assign idle       = idle_q;
  assign bit_idx    = bit_idx_q;
  assign done       = done_q;

endmodule
